// File: rtl/elm_neuron_pkg.sv
// Shared types and helpers for the ELM hidden-layer neuron and its sigmoid ROM.
package elm_neuron_pkg;

  localparam int unsigned ACT_RELU    = 0;
  localparam int unsigned ACT_SIGMOID = 1;
  localparam int unsigned ACT_IDENT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_BIAS,
    ST_ACT,
    ST_OUT
  } state_t;

  // Accumulator width: full product width plus headroom for every weight.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned num_weight);
    return 2 * data_w + $clog2(num_weight);
  endfunction

  // Clamp a signed value to the range of a w-bit signed word.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/elm_sigmoid_lut.sv
// Registered sigmoid ROM: hard-sigmoid 0.5 + x/4 clamped to [0,1], address read as signed x in [-8,8).
module elm_sigmoid_lut #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned SIG_IN_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SIG_IN_W-1:0] addr,
  output logic [DATA_W-1:0]   data
);

  localparam int SH = int'(FRAC_W) + 2 - int'(SIG_IN_W);

  function automatic logic [DATA_W-1:0] sig_at(input logic [SIG_IN_W-1:0] a);
    longint x;
    longint y;
    longint one;
    x   = longint'($signed(a));
    y   = (SH >= 0) ? (x <<< SH) : (x >>> (-SH));
    one = longint'(1) <<< FRAC_W;
    y   = y + (one >>> 1);
    if (y < 0) y = 0;
    else if (y > one) y = one;
    return DATA_W'(y);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else if (en) data <= sig_at(addr);
  end

endmodule

// File: rtl/elm_neuron_mac.sv
// Multi-lane ELM hidden-layer neuron: weight RAM, LANES-wide MAC pipeline, bias, activation.
// Define NEURON_SAT_EN to saturate the accumulator and output reduction instead of wrapping.
module elm_neuron_mac
  import elm_neuron_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned NUM_WEIGHT = 128,
  parameter int unsigned LANES      = 2,
  parameter int unsigned LAYER_NO   = 1,
  parameter int unsigned NEURON_NO  = 0,
  parameter int unsigned ACT_MODE   = 1,
  parameter int unsigned SIG_IN_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cfg_layer,
  input  logic [31:0]               cfg_neuron,
  input  logic                      w_valid,
  input  logic [DATA_W-1:0]         w_data,
  input  logic                      b_valid,
  input  logic [DATA_W-1:0]         b_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      busy
);

  localparam int unsigned ROWS   = NUM_WEIGHT / LANES;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ADDR_W = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned NW_W   = $clog2(NUM_WEIGHT);
  localparam int unsigned ACC_W  = acc_w(DATA_W, NUM_WEIGHT);
  localparam int unsigned PROD_W = 2 * DATA_W;

  state_t state_q, state_d;
  logic [1:0]               drain_cnt;
  logic [ROW_W-1:0]         beat_cnt;
  logic [ADDR_W-1:0]        w_addr;
  logic                     in_ready_q, out_valid_q, busy_q;
  logic [DATA_W-1:0]        out_q, lut_q;
  logic signed [DATA_W-1:0] ram  [LANES][ROWS];
  logic signed [DATA_W-1:0] s1_w [LANES];
  logic signed [DATA_W-1:0] s1_x [LANES];
  logic signed [PROD_W-1:0] s2_p [LANES];
  logic                     v1, v2;
  logic signed [ACC_W-1:0]  acc, bias;
  logic signed [ACC_W-1:0]  tree_c, addend_c, acc_nxt_c;
  logic [DATA_W-1:0]        red_c, act_c;
  logic                     cfg_open_c, in_fire_c, last_beat_c, out_fire_c, lut_en_c;
  logic [LANE_W-1:0]        w_lane_c;
  logic [ROW_W-1:0]         w_row_c;

  assign cfg_open_c  = (cfg_layer == 32'(LAYER_NO)) && (cfg_neuron == 32'(NEURON_NO)) &&
                       (state_q == ST_IDLE);
  assign in_fire_c   = in_valid && in_ready_q;
  assign last_beat_c = (beat_cnt == ROW_W'(ROWS - 1));
  assign out_fire_c  = out_valid_q && out_ready;
  assign w_lane_c    = LANE_W'(w_addr % ADDR_W'(LANES));
  assign w_row_c     = ROW_W'(w_addr / ADDR_W'(LANES));
  assign lut_en_c    = (state_q == ST_ACT);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: if (in_fire_c) state_d = last_beat_c ? ST_DRAIN : ST_ACCUM;
      ST_DRAIN:          if (drain_cnt == 2'd2) state_d = ST_BIAS;
      ST_BIAS:           state_d = ST_ACT;
      ST_ACT:            state_d = ST_OUT;
      ST_OUT:            if (out_fire_c) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Control registers; handshake flags follow the next state so they stay registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt   <= 2'd0;
      beat_cnt    <= '0;
      w_addr      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt   <= (state_q == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (in_fire_c) beat_cnt <= last_beat_c ? '0 : beat_cnt + ROW_W'(1);
      if (w_valid && cfg_open_c)
        w_addr <= (w_addr == ADDR_W'(NUM_WEIGHT - 1)) ? '0 : w_addr + ADDR_W'(1);
      in_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE);
      if (state_q == ST_ACT) out_q <= act_c;
    end
  end

  // Weight RAM and the two data pipeline stages (RAM read, products)
  always_ff @(posedge clk) begin
    if (w_valid && cfg_open_c) ram[w_lane_c][w_row_c] <= w_data;
    for (int k = 0; k < int'(LANES); k++) begin
      s1_w[k] <= ram[k][beat_cnt];
      s1_x[k] <= in_data[k*DATA_W +: DATA_W];
      s2_p[k] <= PROD_W'(s1_w[k]) * PROD_W'(s1_x[k]);
    end
  end

  always_comb begin
    tree_c = '0;
    for (int k = 0; k < int'(LANES); k++) tree_c = tree_c + ACC_W'(s2_p[k]);
    addend_c = (state_q == ST_BIAS) ? bias : tree_c;
  end

`ifdef NEURON_SAT_EN
  logic signed [ACC_W:0] sum_c;
  always_comb begin
    sum_c     = (ACC_W+1)'(acc) + (ACC_W+1)'(addend_c);
    acc_nxt_c = ACC_W'(sat_s(64'(sum_c), ACC_W));
    red_c     = DATA_W'(sat_s(64'(acc >>> FRAC_W), DATA_W));
  end
`else
  always_comb begin
    acc_nxt_c = acc + addend_c;
    red_c     = DATA_W'(acc >>> FRAC_W);
  end
`endif

  always_comb begin
    act_c = red_c;
    if (ACT_MODE == ACT_RELU && acc[ACC_W-1]) act_c = '0;
  end

  // Accumulator, bias register and beat-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      acc  <= '0;
      bias <= '0;
    end else begin
      v1 <= in_fire_c;
      v2 <= v1;
      if (out_fire_c) acc <= '0;
      else if (v2 || state_q == ST_BIAS) acc <= acc_nxt_c;
      if (b_valid && cfg_open_c) bias <= ACC_W'($signed(b_data)) <<< FRAC_W;
    end
  end

  elm_sigmoid_lut #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .SIG_IN_W(SIG_IN_W)
  ) u_sigmoid_lut (
    .clk (clk),
    .rst (rst),
    .en  (lut_en_c),
    .addr(acc[ACC_W-1-NW_W -: SIG_IN_W]),
    .data(lut_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = (ACT_MODE == ACT_SIGMOID) ? lut_q : out_q;

endmodule

// File: tb/tb_elm_neuron_mac.sv
// Scoreboard bench for elm_neuron_mac: ReLU and identity instances share stimulus.
module tb_elm_neuron_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_layer = 32'd1, cfg_neuron = 32'd0;
  logic        w_valid = 1'b0, b_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] w_data = '0, b_data = '0;
  logic [31:0] in_data = '0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [15:0] out_data0, out_data1;

  always #5 clk = ~clk;

  elm_neuron_mac #(.DATA_W(16), .FRAC_W(8), .NUM_WEIGHT(4), .LANES(2), .LAYER_NO(1),
                   .NEURON_NO(0), .ACT_MODE(0), .SIG_IN_W(10)) dut_relu (
    .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0));

  elm_neuron_mac #(.DATA_W(16), .FRAC_W(8), .NUM_WEIGHT(4), .LANES(2), .LAYER_NO(1),
                   .NEURON_NO(0), .ACT_MODE(2), .SIG_IN_W(10)) dut_ident (
    .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1));

  typedef struct {
    logic [15:0] relu;
    logic [15:0] ident;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0, cyc = 0;
  bit          mon_holding = 1'b0;
  logic [15:0] m_w [4];
  logic [15:0] m_bias = '0;
  int          m_waddr = 0;
  logic [15:0] cur_x [4];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic abort(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
    finish_run();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact dot product plus bias in Q.16, then the 34-bit accumulator and 16-bit output rules
  function automatic exp_t predict();
    exp_t   e;
    longint acc;
    longint sh;
    acc = longint'($signed(m_bias)) <<< 8;
    for (int i = 0; i < 4; i++) acc += longint'($signed(m_w[i])) * longint'($signed(cur_x[i]));
`ifdef NEURON_SAT_EN
    if (acc > (longint'(1) <<< 33) - 1) acc = (longint'(1) <<< 33) - 1;
    if (acc < -(longint'(1) <<< 33)) acc = -(longint'(1) <<< 33);
    sh = acc >>> 8;
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
`else
    acc = (acc <<< 30) >>> 30;
    sh  = acc >>> 8;
`endif
    e.ident   = sh[15:0];
    e.relu    = (acc < 0) ? 16'h0000 : sh[15:0];
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic wr_w(input logic [15:0] v, input logic [31:0] l, input logic [31:0] n, input bit idle);
    cfg_layer = l; cfg_neuron = n; w_data = v; w_valid = 1'b1;
    tick();
    w_valid = 1'b0; cfg_layer = 32'd1; cfg_neuron = 32'd0;
    if (idle && l == 32'd1 && n == 32'd0) begin
      m_w[m_waddr] = v;
      m_waddr = (m_waddr + 1) % 4;
    end
  endtask

  task automatic wr_b(input logic [15:0] v, input logic [31:0] l, input logic [31:0] n, input bit idle);
    cfg_layer = l; cfg_neuron = n; b_data = v; b_valid = 1'b1;
    tick();
    b_valid = 1'b0; cfg_layer = 32'd1; cfg_neuron = 32'd0;
    if (idle && l == 32'd1 && n == 32'd0) m_bias = v;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy0 || busy1) begin
      n++;
      if (n > 500) abort("wait_idle");
      @(negedge clk);
    end
    tick();
  endtask

  // Send nbeats beats of cur_x with random gaps; a full vector is pushed to the scoreboard
  task automatic send_vec(input int nbeats);
    exp_t e;
    int   n;
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      in_data  = {cur_x[b*2+1], cur_x[b*2]};
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready0) begin
        n++;
        if (n > 500) abort("in_ready_wait");
        @(negedge clk);
      end
      tick();
      in_valid = 1'b0;
    end
    if (nbeats == 2) begin
      e = predict();
      e.acc_cyc = cyc;
      sb.push_back(e);
      chk("busy_after_last_beat", 32'(busy0), 32'd1);
    end
  endtask

  task automatic fill_x(input logic [15:0] v);
    for (int i = 0; i < 4; i++) cur_x[i] = v;
  endtask

  // Monitor: pops on each new result, holds out_ready low for a random stall, checks stability
  initial begin
    bit          pend;
    int          stall, nres;
    logic [15:0] hold0, hold1;
    exp_t        e;
    pend = 1'b0; stall = 0; nres = 0; hold0 = '0; hold1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; mon_holding = 1'b0; out_ready = 1'b0;
      end else begin
        if (pend) begin
          chk("out_valid_after_hs", 32'(out_valid0), 32'd0);
          chk("in_ready_after_hs", 32'(in_ready0), 32'd1);
          pend = 1'b0; mon_holding = 1'b0; out_ready = 1'b0;
        end
        if (out_valid0) begin
          if (!mon_holding) begin
            if (sb.size() == 0) begin
              chk("unexpected_output", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("relu_data", 32'(out_data0), 32'(e.relu));
              chk("ident_data", 32'(out_data1), 32'(e.ident));
              chk("latency", 32'(cyc - e.acc_cyc), 32'd5);
              chk("ident_out_valid", 32'(out_valid1), 32'd1);
            end
            mon_holding = 1'b1; hold0 = out_data0; hold1 = out_data1;
            stall = (nres == 0 || $urandom_range(0, 4) == 0) ? 10 : int'($urandom_range(0, 2));
            nres++;
          end else begin
            chk("relu_hold_stable", 32'(out_data0), 32'(hold0));
            chk("ident_hold_stable", 32'(out_data1), 32'(hold1));
          end
          chk("in_ready_in_out", 32'(in_ready0), 32'd0);
          if (stall == 0) begin
            out_ready = 1'b1; pend = 1'b1;
          end else begin
            stall--;
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_out_data", 32'(out_data0), 32'd0);
    chk("rst_out_data_sig", 32'(out_data1), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    rst = 1'b0;
    tick();

    // Unit weights, half bias
    for (int i = 0; i < 4; i++) wr_w(16'h0100, 32'd1, 32'd0, 1'b1);
    wr_b(16'h0080, 32'd1, 32'd0, 1'b1);
    fill_x(16'h0100);
    send_vec(2);

    // Negative result: ReLU clamps, identity passes
    wait_idle();
    for (int i = 0; i < 4; i++) wr_w(16'hFF00, 32'd1, 32'd0, 1'b1);
    wr_b(16'h0000, 32'd1, 32'd0, 1'b1);
    send_vec(2);

    // Full-scale operands exceed the output range
    wait_idle();
    for (int i = 0; i < 4; i++) wr_w(16'h7FFF, 32'd1, 32'd0, 1'b1);
    fill_x(16'h7FFF);
    send_vec(2);

    // Mismatched IDs and writes while busy must be ignored
    wait_idle();
    for (int i = 0; i < 4; i++) wr_w(16'h0100, 32'd1, 32'd0, 1'b1);
    wr_b(16'h0080, 32'd1, 32'd0, 1'b1);
    wr_w(16'h1234, 32'd1, 32'd1, 1'b1);
    wr_w(16'h1234, 32'd2, 32'd0, 1'b1);
    wr_b(16'h7777, 32'd1, 32'd3, 1'b1);
    fill_x(16'h0100);
    send_vec(2);
    wr_w(16'h5555, 32'd1, 32'd0, 1'b0);
    wr_b(16'h5555, 32'd1, 32'd0, 1'b0);
    wait_idle();
    wr_w(16'h0300, 32'd1, 32'd0, 1'b1);
    cur_x[0] = 16'h0100; cur_x[1] = 16'h0200; cur_x[2] = 16'h0040; cur_x[3] = 16'hFF80;
    send_vec(2);

    // Reset mid-vector: bias and write pointer cleared, weights kept
    wait_idle();
    fill_x(16'h0100);
    send_vec(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_bias = '0;
    m_waddr = 0;
    chk("midrst_out_valid", 32'(out_valid0), 32'd0);
    chk("midrst_in_ready", 32'(in_ready0), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    for (int i = 0; i < 4; i++) wr_w(16'h0100, 32'd1, 32'd0, 1'b1);
    send_vec(2);

    // Random weights, bias and inputs; some vectors back-to-back
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        wait_idle();
        if ($urandom_range(0, 1) == 1)
          for (int i = 0; i < 4; i++) wr_w(16'($urandom), 32'd1, 32'd0, 1'b1);
        wr_b(16'($urandom), 32'd1, 32'd0, 1'b1);
      end
      for (int i = 0; i < 4; i++) cur_x[i] = 16'($urandom);
      send_vec(2);
    end

    n = 0;
    while (sb.size() != 0 || mon_holding) begin
      n++;
      if (n > 2000) abort("drain_scoreboard");
      tick();
    end
    repeat (3) tick();
    finish_run();
  end

endmodule
